spi_slave_ctrl: RTL

- SPI slave front end that sits directly upstream of the single-port RAM.
- Deserialises MOSI into 10-bit command words `{cmd[1:0], payload[ADDR_SIZE-1:0]}` and presents each word on `rx_data` with a one-cycle `rx_valid` pulse.
- On a read-data frame, captures the RAM's `tx_data`/`tx_valid` response and serialises it back on MISO, MSB first.
- Frames are delimited by `SS_n` (active-low chip select); SPI SCK is `clk`.

---
 rtl/spi_slave_ctrl_pkg.sv | 24 ++
 rtl/spi_slave_ctrl_if.sv | 23 ++
 rtl/spi_slave_ctrl_tx_serializer.sv | 50 +++++
 rtl/spi_slave_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/spi_slave_ctrl_pkg.sv
// Shared types and constants for the SPI slave front end: FSM state encoding,
// command codes and frame length.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } spi_state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int FRAME_BITS = 10;

  function automatic logic is_shift_state(input spi_state_e s);
    return (s == WRITE) || (s == READ_ADD) || (s == READ_DATA);
  endfunction

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// SPI pins plus the RAM-facing word/response handshake of the SPI slave.
interface spi_slave_ctrl_if #(
  parameter int ADDR_SIZE = 8
);
  logic                 SS_n;
  logic                 MOSI;
  logic                 MISO;
  logic [ADDR_SIZE-1:0] tx_data;
  logic                 tx_valid;
  logic [ADDR_SIZE+1:0] rx_data;
  logic                 rx_valid;
  logic                 cmd_err;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, cmd_err
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, cmd_err
  );
endinterface

// File: rtl/spi_slave_ctrl_tx_serializer.sv
// Read-response serialiser: loads one RAM word on tx_valid and shifts it out
// MSB first on a registered MISO, then idles at 0 with a done flag.
module spi_tx_serializer #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic                 i_load_en,
  input  logic                 i_tx_valid,
  input  logic [ADDR_SIZE-1:0] i_tx_data,
  output logic                 o_miso,
  output logic                 o_done
);
  localparam int CNT_W = $clog2(ADDR_SIZE + 1);

  logic [ADDR_SIZE-1:0] r_sreg;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_active;
  logic                 r_done;
  logic                 r_miso;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_sreg   <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
      r_miso   <= 1'b0;
    end else if (i_load_en && i_tx_valid && !r_active && !r_done) begin
      r_sreg   <= i_tx_data;
      r_cnt    <= '0;
      r_active <= 1'b1;
      r_miso   <= 1'b0;
    end else if (r_active) begin
      r_miso <= r_sreg[ADDR_SIZE-1];
      r_sreg <= r_sreg << 1;
      r_cnt  <= r_cnt + CNT_W'(1);
      if (r_cnt == CNT_W'(ADDR_SIZE - 1)) begin
        r_active <= 1'b0;
        r_done   <= 1'b1;
      end
    end else begin
      r_miso <= 1'b0;
    end
  end

  assign o_miso = r_miso;
  assign o_done = r_done;
endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front end: frame FSM and MOSI deserialiser feeding the RAM, with
// the read response serialised by spi_tx_serializer. Optional: SPI_CMD_CHECK_EN.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_SIZE = 8
) (
  input  logic           clk,
  input  logic           rst,
  spi_slave_ctrl_if.slave bus
);
  localparam int RX_W  = ADDR_SIZE + 2;
  localparam int CNT_W = $clog2(RX_W);

  spi_state_e       r_state, w_state_next;
  logic [RX_W-2:0]  r_shift;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_rx_done;
  logic             r_rx_valid;
  logic [RX_W-1:0]  r_rx_data;
  logic             r_cmd_err;
  logic             r_rd_addr_done;

  logic             w_shifting;
  logic             w_last_bit;
  logic [RX_W-1:0]  w_word;
  logic             w_cmd_ok;
  logic             w_miso;
  logic             w_tx_done;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (!bus.SS_n) w_state_next = CHK_CMD;
      CHK_CMD: begin
        if (bus.SS_n)            w_state_next = IDLE;
        else if (!bus.MOSI)      w_state_next = WRITE;
        else if (r_rd_addr_done) w_state_next = READ_DATA;
        else                     w_state_next = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: if (bus.SS_n) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Once the word is complete, further MOSI bits are ignored until SS_n rises.
  assign w_shifting = is_shift_state(r_state) && !bus.SS_n && !r_rx_done;
  assign w_last_bit = w_shifting && (r_bit_cnt == CNT_W'(RX_W - 1));
  assign w_word     = {r_shift, bus.MOSI};

`ifdef SPI_CMD_CHECK_EN
  always_comb begin
    w_cmd_ok = 1'b0;
    case (r_state)
      WRITE:     w_cmd_ok = (w_word[RX_W-1 -: 2] == CMD_WR_ADDR) ||
                            (w_word[RX_W-1 -: 2] == CMD_WR_DATA);
      READ_ADD:  w_cmd_ok = (w_word[RX_W-1 -: 2] == CMD_RD_ADDR);
      READ_DATA: w_cmd_ok = (w_word[RX_W-1 -: 2] == CMD_RD_DATA);
      default:   w_cmd_ok = 1'b0;
    endcase
  end
`else
  assign w_cmd_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift        <= '0;
      r_bit_cnt      <= '0;
      r_rx_done      <= 1'b0;
      r_rx_valid     <= 1'b0;
      r_rx_data      <= '0;
      r_cmd_err      <= 1'b0;
      r_rd_addr_done <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_cmd_err  <= 1'b0;
      if (w_shifting) begin
        r_shift <= w_word[RX_W-2:0];
        if (w_last_bit) begin
          r_rx_done <= 1'b1;
          if (w_cmd_ok) begin
            r_rx_data  <= w_word;
            r_rx_valid <= 1'b1;
            if (r_state == READ_ADD)  r_rd_addr_done <= 1'b1;
            if (r_state == READ_DATA) r_rd_addr_done <= 1'b0;
          end else begin
            r_cmd_err <= 1'b1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
      end else if (bus.SS_n || !is_shift_state(r_state)) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
        r_rx_done <= 1'b0;
      end
    end
  end

  spi_tx_serializer #(.ADDR_SIZE(ADDR_SIZE)) u_tx (
    .clk        (clk),
    .rst        (rst),
    .i_clear    ((r_state != READ_DATA) || bus.SS_n),
    .i_load_en  (r_rx_done),
    .i_tx_valid (bus.tx_valid),
    .i_tx_data  (bus.tx_data),
    .o_miso     (w_miso),
    .o_done     (w_tx_done)
  );

  assign bus.MISO     = w_miso;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.cmd_err  = r_cmd_err;

  logic w_unused;
  assign w_unused = w_tx_done;
endmodule
